// File: rtl/galois_div_small_254_if.sv
// rtl/galois_div_small_254_if.sv - operand/result handshake bundle for galois_div_small_254
interface galois_div_small_254_if #(
  parameter int WIDTH = 254,
  parameter int KW    = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [KW-1:0]    num1;
  logic [WIDTH-1:0] num2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    output in_valid, num1, num2, out_ready,
    input  in_ready, out_valid, result, err
  );

  modport slave (
    input  in_valid, num1, num2, out_ready,
    output in_ready, out_valid, result, err
  );
endinterface

// File: rtl/galois_div_small_254.sv
// rtl/galois_div_small_254.sv - bit-serial x * k^-1 mod the BN254 scalar prime
// Optional macro GALOIS_DIV_FAST1_EN: k==1 goes straight from IDLE to DONE with result=x.
module galois_div_small_254 #(
  parameter int               WIDTH = 254,
  parameter int               KW    = 5,
  parameter logic [WIDTH-1:0] PRIME = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001
) (
  input logic                   clk,
  input logic                   rst_n,
  galois_div_small_254_if.slave bus
);

  localparam int NW = WIDTH + KW;
  localparam int CW = $clog2(NW);
  localparam int XW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, REM, SEARCH, MUL, DIV, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] x;
  logic [KW-1:0]    k;
  logic [KW-1:0]    rx;
  logic [KW-1:0]    rp;
  logic [KW-1:0]    t;
  logic [KW-1:0]    rem;
  logic [NW-1:0]    n;
  logic [CW-1:0]    cnt;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             err_q;
  logic [WIDTH-1:0] result_q;

  logic [KW:0]      k_ext;
  logic [KW:0]      rx_dbl;
  logic [KW:0]      rp_dbl;
  logic [KW:0]      acc_sum;
  logic [KW:0]      rem_sh;
  logic [KW-1:0]    rx_step;
  logic [KW-1:0]    rp_step;
  logic [KW-1:0]    acc_step;
  logic [KW-1:0]    rem_step;
  logic             q_bit;
  logic [NW-1:0]    n_mul;
  logic [KW-1:0]    first_rx;
  logic [KW-1:0]    first_rp;

  // All residues stay below k, so each doubling/addition needs at most one subtract.
  always_comb begin
    k_ext    = {1'b0, k};
    rx_dbl   = {rx, x[cnt[XW-1:0]]};
    rp_dbl   = {rp, PRIME[cnt[XW-1:0]]};
    rx_step  = KW'((rx_dbl >= k_ext) ? rx_dbl - k_ext : rx_dbl);
    rp_step  = KW'((rp_dbl >= k_ext) ? rp_dbl - k_ext : rp_dbl);
    acc_sum  = {1'b0, rx} + {1'b0, rp};
    acc_step = KW'((acc_sum >= k_ext) ? acc_sum - k_ext : acc_sum);
    rem_sh   = {rem, n[NW-1]};
    q_bit    = (rem_sh >= k_ext);
    rem_step = KW'(q_bit ? rem_sh - k_ext : rem_sh);
    n_mul    = NW'(x) + NW'(t) * NW'(PRIME);
  end

  // The top bit is folded into the accept edge: a single bit mod k is the bit itself unless k==1.
  always_comb begin
    first_rx = KW'(bus.num2[WIDTH-1] && (bus.num1 != KW'(1)));
    first_rp = KW'(PRIME[WIDTH-1] && (bus.num1 != KW'(1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      x           <= '0;
      k           <= '0;
      rx          <= '0;
      rp          <= '0;
      t           <= '0;
      rem         <= '0;
      n           <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      result_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x          <= bus.num2;
            k          <= bus.num1;
            rx         <= first_rx;
            rp         <= first_rp;
            t          <= '0;
            rem        <= '0;
            cnt        <= CW'(WIDTH - 2);
            in_ready_q <= 1'b0;
            result_q   <= '0;
            if (bus.num1 == '0) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              err_q       <= 1'b1;
`ifdef GALOIS_DIV_FAST1_EN
            end else if (bus.num1 == KW'(1)) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              err_q       <= 1'b0;
              result_q    <= bus.num2;
`endif
            end else begin
              state <= REM;
              err_q <= 1'b0;
            end
          end
        end
        REM: begin
          rx <= rx_step;
          rp <= rp_step;
          if (cnt == '0) begin
            state <= SEARCH;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        // Find t with x + t*PRIME == 0 (mod k); rx doubles as the running accumulator.
        SEARCH: begin
          if (rx == '0) begin
            state <= MUL;
          end else begin
            rx <= acc_step;
            t  <= t + KW'(1);
          end
        end
        MUL: begin
          n     <= n_mul;
          rem   <= '0;
          cnt   <= CW'(NW - 1);
          state <= DIV;
        end
        DIV: begin
          n   <= {n[NW-2:0], q_bit};
          rem <= rem_step;
          if (cnt == '0) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= {n[WIDTH-2:0], q_bit};
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_galois_div_small_254.sv
// tb/tb_galois_div_small_254.sv - directed-vector bench for galois_div_small_254
module tb_galois_div_small_254;

  localparam int               WIDTH = 254;
  localparam int               KW    = 5;
  localparam int               CHKW  = WIDTH + 6;
  localparam logic [WIDTH-1:0] PRIME = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  localparam logic [WIDTH-1:0] HALF1 = 254'h183227397098d014dc2822db40c0ac2e9419f4243cdcb848a1f0fac9f8000001;
  localparam logic [WIDTH-1:0] X_T4  = 254'h290877c6917e71668768241b2a306a0bcebd91a60aa18177727bbb54d3cc914d;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  galois_div_small_254_if #(.WIDTH(WIDTH), .KW(KW)) bus ();

  galois_div_small_254 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [CHKW-1:0] got, input logic [CHKW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Checks result*k == x (mod PRIME) and result < PRIME with a wide-integer model.
  task automatic chk_inv(input string tag, input logic [KW-1:0] k, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] res);
    logic [CHKW-1:0] prod;
    prod = CHKW'(res) * CHKW'(k);
    prod = prod % CHKW'(PRIME);
    chk({tag, "_mod"}, prod, CHKW'(x));
    chk({tag, "_lt"}, CHKW'(res < PRIME), CHKW'(1));
  endtask

  task automatic run_op(input logic [KW-1:0] k, input logic [WIDTH-1:0] x,
                        output int lat, output logic [WIDTH-1:0] res, output logic e);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.num1     = k;
    bus.num2     = x;
    n = 0;
    while (!bus.in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", CHKW'(bus.in_ready), CHKW'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.num1     = ~k;
    bus.num2     = ~x;
    lat = 1;
    while (!bus.out_valid && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("out_valid_seen", CHKW'(bus.out_valid), CHKW'(1));
    res = bus.result;
    e   = bus.err;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  int               lat;
  logic [WIDTH-1:0] res;
  logic             e;
  logic [KW-1:0]    rk;
  logic [WIDTH-1:0] rx;
  logic [255:0]     rnd;

  initial begin
    bus.in_valid  = 1'b0;
    bus.num1      = '0;
    bus.num2      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", CHKW'(bus.in_ready), CHKW'(1));
    chk("rst_out_valid", CHKW'(bus.out_valid), CHKW'(0));
    chk("rst_result", CHKW'(bus.result), CHKW'(0));
    chk("rst_err", CHKW'(bus.err), CHKW'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // T1: exact division, t=0
    run_op(5'd23, 254'd115, lat, res, e);
    chk("t1_lat", CHKW'(lat), CHKW'(515));
    chk("t1_result", CHKW'(res), CHKW'(5));
    chk("t1_err", CHKW'(e), CHKW'(0));
    chk("t1_in_ready_busy", CHKW'(bus.in_ready), CHKW'(0));
    consume();
    chk("t1_valid_drop", CHKW'(bus.out_valid), CHKW'(0));
    chk("t1_in_ready_back", CHKW'(bus.in_ready), CHKW'(1));

    // T2: 1/2 mod PRIME, t=1
    run_op(5'd2, 254'd1, lat, res, e);
    chk("t2_lat", CHKW'(lat), CHKW'(516));
    chk("t2_result", CHKW'(res), CHKW'(HALF1));
    consume();

    // T3: divide by zero
    run_op(5'd0, 254'h1234, lat, res, e);
    chk("t3_lat", CHKW'(lat), CHKW'(1));
    chk("t3_err", CHKW'(e), CHKW'(1));
    chk("t3_result", CHKW'(res), CHKW'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("t3_in_ready_hold", CHKW'(bus.in_ready), CHKW'(0));
    chk("t3_valid_hold", CHKW'(bus.out_valid), CHKW'(1));
    consume();
    chk("t3_in_ready_back", CHKW'(bus.in_ready), CHKW'(1));

    // T4: general element, result held while out_ready=0
    run_op(5'd23, X_T4, lat, res, e);
    chk_inv("t4", 5'd23, X_T4, res);
    chk("t4_err", CHKW'(e), CHKW'(0));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("t4_stable", CHKW'(bus.result), CHKW'(res));
      chk("t4_busy", CHKW'({bus.out_valid, bus.in_ready}), CHKW'(2'b10));
    end
    consume();

    // k==1 and x==0 boundaries
    run_op(5'd1, 254'hbeef, lat, res, e);
`ifdef GALOIS_DIV_FAST1_EN
    chk("k1_lat", CHKW'(lat), CHKW'(1));
`else
    chk("k1_lat", CHKW'(lat), CHKW'(515));
`endif
    chk("k1_result", CHKW'(res), CHKW'(254'hbeef));
    consume();
    run_op(5'd7, 254'd0, lat, res, e);
    chk("x0_lat", CHKW'(lat), CHKW'(515));
    chk("x0_result", CHKW'(res), CHKW'(0));
    consume();
    run_op(5'd31, PRIME - 254'd1, lat, res, e);
    chk_inv("pm1_k31", 5'd31, PRIME - 254'd1, res);
    consume();

    // T5: reset mid-DIV aborts the operation
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.num1     = 5'd23;
    bus.num2     = 254'd115;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (400) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", CHKW'(bus.out_valid), CHKW'(0));
    chk("t5_rst_ready", CHKW'(bus.in_ready), CHKW'(1));
    @(negedge clk);
    rst_n = 1'b1;
    run_op(5'd23, 254'd115, lat, res, e);
    chk("t5_lat", CHKW'(lat), CHKW'(515));
    chk("t5_result", CHKW'(res), CHKW'(5));
    consume();

    // T6: random back-to-back operations with random consumer stalls
    for (int j = 0; j < 40; j++) begin
      for (int w = 0; w < 8; w++) rnd[w*32 +: 32] = $urandom;
      rx = WIDTH'(rnd % 256'(PRIME));
      rk = KW'($urandom_range(1, 31));
      run_op(rk, rx, lat, res, e);
      chk_inv("t6", rk, rx, res);
      chk("t6_err", CHKW'(e), CHKW'(0));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      chk("t6_held", CHKW'(bus.result), CHKW'(res));
      consume();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
